// File: rtl/relu_dst_serializer.sv
// relu_dst_serializer
//   Consumer end of the relu dst interface. Each 8-lane unpacked float vector
//   is captured into a small vector FIFO. It is then serialized lane by lane
//   as packed {sign,exp,man} words on a valid/ready stream. o_enable gives the
//   relu stage credit-style flow control: it drops while SLACK or fewer slots
//   are free, so vectors already in flight in the relu pipeline still fit.
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_dst_valid                lane vector valid (no backpressure on this side)
//   i_dst_{man,exp,sign}_k     lane k fields, k = 0..7
//   o_enable                   high = room for SLACK+1 more vectors
//   o_out_valid/i_out_ready    output word handshake
//   o_out_data                 {sign,exp[7:0],man[22:0]} of lane o_out_lane
//   o_out_lane, o_out_last     lane index, high on lane 7
//   o_overflow                 sticky: a vector arrived with the FIFO full and no pop
module relu_dst_serializer #(
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dst_valid,
  input  logic [22:0] i_dst_man_0, i_dst_man_1, i_dst_man_2, i_dst_man_3,
  input  logic [22:0] i_dst_man_4, i_dst_man_5, i_dst_man_6, i_dst_man_7,
  input  logic [7:0]  i_dst_exp_0, i_dst_exp_1, i_dst_exp_2, i_dst_exp_3,
  input  logic [7:0]  i_dst_exp_4, i_dst_exp_5, i_dst_exp_6, i_dst_exp_7,
  input  logic        i_dst_sign_0, i_dst_sign_1, i_dst_sign_2, i_dst_sign_3,
  input  logic        i_dst_sign_4, i_dst_sign_5, i_dst_sign_6, i_dst_sign_7,
  output logic        o_enable,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic [2:0]  o_out_lane,
  output logic        o_out_last,
  output logic        o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [255:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;
  logic [2:0]    r_lane_cnt;
  logic [31:0]   r_out_data;
  logic          r_out_last;
  logic          r_enable;
  logic          r_overflow;

  logic [255:0]  w_vec;
  logic          w_pop, w_push, w_drop, w_full;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_room;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [2:0]    w_lane_nxt;
  logic [255:0]  w_next_head;

  // Lane 0 sits in the least significant word.
  assign w_vec = {i_dst_sign_7, i_dst_exp_7, i_dst_man_7,
                  i_dst_sign_6, i_dst_exp_6, i_dst_man_6,
                  i_dst_sign_5, i_dst_exp_5, i_dst_man_5,
                  i_dst_sign_4, i_dst_exp_4, i_dst_man_4,
                  i_dst_sign_3, i_dst_exp_3, i_dst_man_3,
                  i_dst_sign_2, i_dst_exp_2, i_dst_man_2,
                  i_dst_sign_1, i_dst_exp_1, i_dst_man_1,
                  i_dst_sign_0, i_dst_exp_0, i_dst_man_0};

  assign w_full = (r_count == FULL);
  assign w_pop  = (r_state == STREAM) && i_out_ready && (r_lane_cnt == 3'd7);
  // A full FIFO still accepts a vector when the head pops in the same cycle.
  assign w_push = i_dst_valid && (!w_full || w_pop);
  assign w_drop = i_dst_valid && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
  end

  assign w_room       = 32'(DEPTH) - 32'(w_count_next);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);
  assign w_lane_nxt   = r_lane_cnt + 3'd1;

  // Next head after a pop. With one entry left, any simultaneous push lands
  // exactly in the next-head slot, so forward it instead of reading stale
  // storage. That keeps back-to-back vectors bubble free.
  assign w_next_head = (w_push && (r_count == ONE)) ? w_vec : r_mem[w_rd_ptr_nxt];

  // Storage is not reset; occupancy is tracked by r_count and the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_vec;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= IDLE;
      r_lane_cnt <= 3'd0;
      r_out_data <= 32'd0;
      r_out_last <= 1'b0;
      r_enable   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_enable <= (w_room > 32'(SLACK));
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state    <= STREAM;
            r_lane_cnt <= 3'd0;
            r_out_data <= r_mem[r_rd_ptr][31:0];
            r_out_last <= 1'b0;
          end
        end
        default: begin
          // Outputs only move on a handshake; a stall holds them stable.
          if (i_out_ready) begin
            if (r_lane_cnt == 3'd7) begin
              r_lane_cnt <= 3'd0;
              r_out_last <= 1'b0;
              if (w_count_next != '0) begin
                r_out_data <= w_next_head[31:0];
              end else begin
                r_state    <= IDLE;
                r_out_data <= 32'd0;
              end
            end else begin
              r_lane_cnt <= w_lane_nxt;
              r_out_data <= r_mem[r_rd_ptr][{w_lane_nxt, 5'b0} +: 32];
              r_out_last <= (w_lane_nxt == 3'd7);
            end
          end
        end
      endcase
    end
  end

  assign o_out_valid = (r_state == STREAM);
  assign o_out_data  = r_out_data;
  assign o_out_lane  = r_lane_cnt;
  assign o_out_last  = r_out_last;
  assign o_enable    = r_enable;
  assign o_overflow  = r_overflow;
endmodule
